wb_decode_bridge: RTL and testbench
===================================

Name: wb_decode_bridge

Overview:
- Parametrised Wishbone classic-cycle bridge: one master port fanned out to N_SLAVES slave ports, selected by decoding the upper address bits.
- Request and response are registered at the boundary, which breaks the combinational ack path between master and slaves.
- An unmapped address returns a bus error instead of hanging.
- Sits between the core's Wishbone master and peripheral blocks (UART, GPIO, timers).

Parameters:
- ADDR_W, 8, master address width.
- DATA_W, 32, data width.
- SELECT_W, 4, byte-select width (DATA_W/8).
- N_SLAVES, 3, number of slave ports, 1..16.
- IDX_W, $clog2(N_SLAVES) (min 1), slave-index field width; localparam.
- TIMEOUT_CYC, 255, cycles to wait for a slave ack; only used with WB_DECODE_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m_address  in  ADDR_W  master address
- m_data_out  in  DATA_W  master write data
- m_we  in  1  write enable
- m_sel  in  SELECT_W  byte selects
- m_stb  in  1  strobe
- m_cyc  in  1  bus cycle
- m_ack  out  1  cycle done, one-cycle pulse
- m_err  out  1  error termination, one-cycle pulse
- m_data_in  out  DATA_W  read data, valid with m_ack
- s_address  out  ADDR_W  registered address, shared by all slaves (full address, index bits included)
- s_data_out  out  DATA_W  registered write data, shared
- s_we  out  1  registered write enable, shared
- s_sel  out  SELECT_W  registered selects, shared
- s_stb  out  N_SLAVES  per-slave strobe, one-hot or zero
- s_cyc  out  N_SLAVES  per-slave cycle, one-hot or zero
- s_ack  in  N_SLAVES  per-slave ack
- s_data_in  in  N_SLAVES*DATA_W  per-slave read data; slave i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Decode: idx = m_address[ADDR_W-1 -: IDX_W]. idx >= N_SLAVES is a decode miss.
- Reset (rstn low, asynchronous): state IDLE; all outputs 0 (m_ack, m_err, m_data_in, s_*).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On m_cyc & m_stb, register address, write data, we, sel and idx.
  - Valid idx: go to WAIT and assert s_cyc[idx] and s_stb[idx] from the next cycle.
  - Miss: go to RESP with err flag set; no slave is touched.
- WAIT:
  - Hold s_cyc[idx] and s_stb[idx] until s_ack[idx] is sampled high.
  - Then, on that edge: drop s_stb and s_cyc, capture s_data_in[idx] into m_data_in (reads; writes leave m_data_in unchanged), go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP:
  - m_ack = 1 (or m_err = 1 on a miss or timeout) for exactly one cycle; next state IDLE.
  - m_data_in holds its value until the next read response.
- Latency:
  - Request sampled at edge 0; slave sees stb after edge 0.
  - A slave acking in its first stb cycle gives m_ack after edge 2: minimum 2 cycles, +1 per slave wait state.
  - Decode miss: m_err after edge 1.
- The master must keep stb/cyc high until ack/err (classic cycle). The bridge ignores stb while in the RESP cycle, so no double acceptance occurs.
- Master abort: m_cyc low while in WAIT → drop s_stb and s_cyc on the next edge and return to IDLE; no m_ack or m_err is issued and any s_ack in that same cycle is discarded.
- At most one outstanding transaction; no pipelining.
- Reset mid-transaction: everything clears immediately; slave strobes drop asynchronously.

Optional Feature:
- Macro: WB_DECODE_TIMEOUT_EN.
- Defined:
  - A cycle counter ($clog2(TIMEOUT_CYC+1) bits) clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYC: drop slave stb/cyc, go to RESP with err, m_data_in unchanged.
  - An ack in the same cycle as the timeout wins (normal ack).
- Not defined: no counter; WAIT lasts until ack or master abort.

Decomposition:
- Package wb_decode_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - a request struct (address, data, we, sel, idx);
  - a function computing IDX_W from N_SLAVES.
- Optional sub-module: wb_addr_decode, combinational address → {idx, miss}, reusable by a future multi-master crossbar.

Test Plan:
- Read, slave 1 acks after 3 wait states: m_address=0x45, s_data_in[1]=0xCAFEF00D → only s_stb[1] high; m_ack one cycle after s_ack; m_data_in=0xCAFEF00D; m_err=0.
- Write to slave 0 with 0-wait ack: m_address=0x10, m_data_out=0x12345678, m_sel=4'b0101 → s_address=0x10, s_data_out, s_sel and s_we=1 match the request; m_ack 2 cycles after request.
- Decode miss at m_address=0xC0 (idx 3, N_SLAVES=3) → m_err pulse after 1 cycle; s_stb stays 0; m_ack=0.
- Master drops m_cyc in WAIT after 2 cycles → s_stb/s_cyc drop next cycle; no m_ack/m_err; a following request completes normally.
- WB_DECODE_TIMEOUT_EN with TIMEOUT_CYC=8 and slave 2 never acking → m_err after 8 WAIT cycles; s_stb[2] cleared. Variant: ack arrives exactly at cycle 8 → m_ack, no m_err.
- rstn asserted mid-WAIT → all s_stb/s_cyc/m_ack/m_err are 0 immediately; after release, bridge is in IDLE and accepts a new read.

Source files
------------

// File: rtl/wb_decode_pkg.sv
// Shared types for the Wishbone address-decode bridge: FSM states, the captured
// request record and the slave-index width helper.
package wb_decode_pkg;

    // Request fields are sized for the widest supported configuration; the
    // bridge zero-extends into them and slices back to its own widths.
    localparam int REQ_ADDR_MAX = 64;
    localparam int REQ_DATA_MAX = 128;
    localparam int REQ_SEL_MAX  = 16;
    localparam int REQ_IDX_MAX  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [REQ_DATA_MAX-1:0] data;
        logic                    we;
        logic [REQ_SEL_MAX-1:0]  sel;
        logic [REQ_IDX_MAX-1:0]  idx;
    } req_t;

    function automatic int calc_idx_w(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

endpackage

// File: rtl/wb_decode_bridge_if.sv
// Bus bundle for wb_decode_bridge: the upstream master port plus the fanned-out
// slave ports. Modports: master (core side), slave (bridge side), periph (peripherals).
interface wb_decode_bridge_if #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int SELECT_W = 4,
    parameter int N_SLAVES = 3
);
    logic [ADDR_W-1:0]          m_address;
    logic [DATA_W-1:0]          m_data_out;
    logic                       m_we;
    logic [SELECT_W-1:0]        m_sel;
    logic                       m_stb;
    logic                       m_cyc;
    logic                       m_ack;
    logic                       m_err;
    logic [DATA_W-1:0]          m_data_in;

    logic [ADDR_W-1:0]          s_address;
    logic [DATA_W-1:0]          s_data_out;
    logic                       s_we;
    logic [SELECT_W-1:0]        s_sel;
    logic [N_SLAVES-1:0]        s_stb;
    logic [N_SLAVES-1:0]        s_cyc;
    logic [N_SLAVES-1:0]        s_ack;
    logic [N_SLAVES*DATA_W-1:0] s_data_in;

    modport master (
        output m_address, m_data_out, m_we, m_sel, m_stb, m_cyc,
        input  m_ack, m_err, m_data_in
    );

    modport slave (
        input  m_address, m_data_out, m_we, m_sel, m_stb, m_cyc,
        output m_ack, m_err, m_data_in,
        output s_address, s_data_out, s_we, s_sel, s_stb, s_cyc,
        input  s_ack, s_data_in
    );

    modport periph (
        input  s_address, s_data_out, s_we, s_sel, s_stb, s_cyc,
        output s_ack, s_data_in
    );
endinterface

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: upper address bits select a slave index;
// indices at or beyond N_SLAVES are reported as a miss.
module wb_addr_decode #(
    parameter int ADDR_W   = 8,
    parameter int N_SLAVES = 3,
    parameter int IDX_W    = 2
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              miss
);
    assign idx  = addr[ADDR_W-1 -: IDX_W];
    assign miss = (32'(idx) >= 32'(N_SLAVES));
endmodule

// File: rtl/wb_decode_bridge.sv
// Registered Wishbone classic-cycle bridge, one master fanned out to N_SLAVES.
// Define WB_DECODE_TIMEOUT_EN to terminate unanswered slave cycles with m_err.
module wb_decode_bridge
    import wb_decode_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int SELECT_W    = 4,
    parameter int N_SLAVES    = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rstn,
    wb_decode_bridge_if.slave bus
);
    localparam int IDX_W = calc_idx_w(N_SLAVES);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              m_ack_q, m_ack_d;
    logic              m_err_q, m_err_d;

    logic [IDX_W-1:0]    dec_idx;
    logic                dec_miss;
    logic [IDX_W-1:0]    cur_idx;
    logic                slave_ack;
    logic [DATA_W-1:0]   slave_rdata;
    logic                accept;
    logic                timeout_hit;
    logic [N_SLAVES-1:0] stb_vec;

    wb_addr_decode #(
        .ADDR_W  (ADDR_W),
        .N_SLAVES(N_SLAVES),
        .IDX_W   (IDX_W)
    ) u_addr_decode (
        .addr(bus.m_address),
        .idx (dec_idx),
        .miss(dec_miss)
    );

    assign cur_idx     = req_q.idx[IDX_W-1:0];
    assign slave_ack   = bus.s_ack[cur_idx];
    assign slave_rdata = bus.s_data_in[int'(cur_idx)*DATA_W +: DATA_W];
    // While the response pulse is visible the master still holds stb; do not re-accept it.
    assign accept      = bus.m_cyc & bus.m_stb & ~(m_ack_q | m_err_q);

`ifdef WB_DECODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT && !slave_ack) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
`endif

    // NOTE: state flops use non-blocking assignments; reset clears every flop so outputs start at 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            m_ack_q <= 1'b0;
            m_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            m_ack_q <= m_ack_d;
            m_err_q <= m_err_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.addr = REQ_ADDR_MAX'(bus.m_address);
                    req_d.data = REQ_DATA_MAX'(bus.m_data_out);
                    req_d.we   = bus.m_we;
                    req_d.sel  = REQ_SEL_MAX'(bus.m_sel);
                    req_d.idx  = REQ_IDX_MAX'(dec_idx);
                    err_d      = dec_miss;
                    state_d    = dec_miss ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!bus.m_cyc) begin
                    state_d = IDLE;
                end else if (slave_ack) begin
                    if (!req_q.we) rdata_d = slave_rdata;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stb_vec = '0;
        if (state_q == WAIT) stb_vec[cur_idx] = 1'b1;
        m_ack_d = (state_q == RESP) && !err_q;
        m_err_d = (state_q == RESP) && err_q;
    end

    assign bus.s_stb      = stb_vec;
    assign bus.s_cyc      = stb_vec;
    assign bus.s_address  = req_q.addr[ADDR_W-1:0];
    assign bus.s_data_out = req_q.data[DATA_W-1:0];
    assign bus.s_we       = req_q.we;
    assign bus.s_sel      = req_q.sel[SELECT_W-1:0];
    assign bus.m_ack      = m_ack_q;
    assign bus.m_err      = m_err_q;
    assign bus.m_data_in  = rdata_q;

    // Request fields above the configured widths are always zero.
    logic unused_req_bits;
    assign unused_req_bits = ^req_q;

endmodule

// File: tb/tb_wb_decode_bridge.sv
// Directed self-checking bench for wb_decode_bridge (3 slaves, 8-bit address);
// timeout cases run only when WB_DECODE_TIMEOUT_EN is defined.
module tb_wb_decode_bridge;
    import wb_decode_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int SELECT_W = 4;
    localparam int N_SLAVES = 3;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    wb_decode_bridge_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SELECT_W(SELECT_W), .N_SLAVES(N_SLAVES)
    ) bus ();

    wb_decode_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SELECT_W(SELECT_W),
        .N_SLAVES(N_SLAVES), .TIMEOUT_CYC(8)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic master_req(input logic [7:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [3:0] sel);
        bus.m_address  = addr;
        bus.m_we       = we;
        bus.m_data_out = wdata;
        bus.m_sel      = sel;
        bus.m_stb      = 1'b1;
        bus.m_cyc      = 1'b1;
    endtask

    task automatic master_idle();
        bus.m_stb = 1'b0;
        bus.m_cyc = 1'b0;
        bus.m_we  = 1'b0;
    endtask

    // Read with slaves acking in their first strobed cycle; waits a bounded number of cycles.
    task automatic wb_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic seen;
        seen = 1'b0;
        master_req(addr, 1'b0, 32'h0, 4'hF);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.m_ack) seen = 1'b1;
            bus.s_ack = bus.s_stb;
        end
        check({tag, "_ack_seen"}, 64'(seen), 64'd1);
        check({tag, "_data"}, 64'(bus.m_data_in), 64'(exp));
        check({tag, "_no_err"}, 64'(bus.m_err), 64'd0);
        master_idle();
        bus.s_ack = '0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        bus.m_address  = '0;
        bus.m_data_out = '0;
        bus.m_sel      = '0;
        master_idle();
        bus.s_ack      = '0;
        bus.s_data_in  = {32'h3333_3333, 32'hCAFE_F00D, 32'hDEAD_BEEF};

        repeat (3) @(negedge clk);
        check("rst_m_ack",  64'(bus.m_ack), 64'd0);
        check("rst_m_err",  64'(bus.m_err), 64'd0);
        check("rst_s_stb",  64'(bus.s_stb), 64'd0);
        check("rst_s_cyc",  64'(bus.s_cyc), 64'd0);
        check("rst_rdata",  64'(bus.m_data_in), 64'd0);
        check("rst_s_addr", 64'(bus.s_address), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Read from slave 1 with three wait states; a stray ack from slave 0 must be ignored.
        master_req(8'h45, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check("rd_stb_onehot", 64'(bus.s_stb), 64'b010);
        check("rd_cyc_onehot", 64'(bus.s_cyc), 64'b010);
        check("rd_s_addr",     64'(bus.s_address), 64'h45);
        bus.s_ack = 3'b001;
        @(negedge clk);
        check("rd_stray_ack_ignored", 64'(bus.s_stb), 64'b010);
        check("rd_wait_no_ack", 64'(bus.m_ack), 64'd0);
        bus.s_ack = 3'b000;
        @(negedge clk);
        check("rd_wait2_stb", 64'(bus.s_stb), 64'b010);
        @(negedge clk);
        bus.s_ack = 3'b010;
        @(negedge clk);
        bus.s_ack = 3'b000;
        check("rd_stb_dropped", 64'(bus.s_stb), 64'd0);
        check("rd_ack_not_yet", 64'(bus.m_ack), 64'd0);
        check("rd_data_captured", 64'(bus.m_data_in), 64'hCAFE_F00D);
        @(negedge clk);
        check("rd_m_ack", 64'(bus.m_ack), 64'd1);
        check("rd_m_err", 64'(bus.m_err), 64'd0);
        check("rd_m_data", 64'(bus.m_data_in), 64'hCAFE_F00D);
        @(negedge clk);
        check("rd_ack_one_cycle", 64'(bus.m_ack), 64'd0);
        check("rd_no_reaccept", 64'(bus.s_stb), 64'd0);
        master_idle();
        @(negedge clk);

        // Zero-wait write to slave 0.
        master_req(8'h10, 1'b1, 32'h1234_5678, 4'b0101);
        @(negedge clk);
        check("wr_s_addr", 64'(bus.s_address), 64'h10);
        check("wr_s_data", 64'(bus.s_data_out), 64'h1234_5678);
        check("wr_s_sel",  64'(bus.s_sel), 64'b0101);
        check("wr_s_we",   64'(bus.s_we), 64'd1);
        check("wr_stb",    64'(bus.s_stb), 64'b001);
        bus.s_ack = 3'b001;
        @(negedge clk);
        bus.s_ack = 3'b000;
        check("wr_ack_not_yet", 64'(bus.m_ack), 64'd0);
        @(negedge clk);
        check("wr_m_ack", 64'(bus.m_ack), 64'd1);
        check("wr_rdata_kept", 64'(bus.m_data_in), 64'hCAFE_F00D);
        master_idle();
        @(negedge clk);
        check("wr_ack_cleared", 64'(bus.m_ack), 64'd0);

        // Decode miss: index 3 with three slaves.
        master_req(8'hC0, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check("miss_no_stb", 64'(bus.s_stb), 64'd0);
        check("miss_err_not_yet", 64'(bus.m_err), 64'd0);
        @(negedge clk);
        check("miss_m_err", 64'(bus.m_err), 64'd1);
        check("miss_m_ack", 64'(bus.m_ack), 64'd0);
        check("miss_stb_still0", 64'(bus.s_stb), 64'd0);
        master_idle();
        @(negedge clk);
        check("miss_err_cleared", 64'(bus.m_err), 64'd0);

        // Master abort in WAIT with a coincident slave ack that must be discarded.
        bus.s_data_in[2*DATA_W +: DATA_W] = 32'h0BAD_F00D;
        master_req(8'h80, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check("abort_stb", 64'(bus.s_stb), 64'b100);
        @(negedge clk);
        master_idle();
        bus.s_ack = 3'b100;
        @(negedge clk);
        bus.s_ack = 3'b000;
        check("abort_stb_dropped", 64'(bus.s_stb), 64'd0);
        check("abort_cyc_dropped", 64'(bus.s_cyc), 64'd0);
        @(negedge clk);
        check("abort_no_ack", 64'(bus.m_ack), 64'd0);
        check("abort_no_err", 64'(bus.m_err), 64'd0);
        check("abort_rdata_kept", 64'(bus.m_data_in), 64'hCAFE_F00D);
        bus.s_data_in[2*DATA_W +: DATA_W] = 32'h5A5A_1234;
        wb_read("post_abort", 8'h80, 32'h5A5A_1234);

`ifdef WB_DECODE_TIMEOUT_EN
        // Slave 2 never acks: eight WAIT cycles then an error pulse.
        master_req(8'h80, 1'b0, 32'h0, 4'hF);
        repeat (8) @(negedge clk);
        check("to_stb_held", 64'(bus.s_stb), 64'b100);
        @(negedge clk);
        check("to_stb_cleared", 64'(bus.s_stb), 64'd0);
        @(negedge clk);
        check("to_m_err", 64'(bus.m_err), 64'd1);
        check("to_m_ack", 64'(bus.m_ack), 64'd0);
        check("to_rdata_kept", 64'(bus.m_data_in), 64'h5A5A_1234);
        master_idle();
        @(negedge clk);

        // Ack in the eighth WAIT cycle beats the timeout.
        bus.s_data_in[2*DATA_W +: DATA_W] = 32'h0808_0808;
        master_req(8'h80, 1'b0, 32'h0, 4'hF);
        repeat (8) @(negedge clk);
        bus.s_ack = 3'b100;
        @(negedge clk);
        bus.s_ack = 3'b000;
        @(negedge clk);
        check("to_race_m_ack", 64'(bus.m_ack), 64'd1);
        check("to_race_m_err", 64'(bus.m_err), 64'd0);
        check("to_race_data", 64'(bus.m_data_in), 64'h0808_0808);
        master_idle();
        @(negedge clk);
`endif

        // Reset asserted mid-WAIT clears outputs without waiting for a clock edge.
        master_req(8'h45, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check("rstw_stb_before", 64'(bus.s_stb), 64'b010);
        #2 rstn = 1'b0;
        #1;
        check("rstw_stb", 64'(bus.s_stb), 64'd0);
        check("rstw_cyc", 64'(bus.s_cyc), 64'd0);
        check("rstw_m_ack", 64'(bus.m_ack), 64'd0);
        check("rstw_m_err", 64'(bus.m_err), 64'd0);
        check("rstw_rdata", 64'(bus.m_data_in), 64'd0);
        master_idle();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus.s_data_in[1*DATA_W +: DATA_W] = 32'h600D_CAFE;
        wb_read("post_reset", 8'h45, 32'h600D_CAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
